blood_fx_controller: RTL and testbench
======================================

Name: blood_fx_controller

Overview:
- Sequences the blood-splatter sprite ROMs (64x64 pixels, 12-bit RGB, 1-cycle registered address latency) for hit effects on both fighters.
- Holds one effect slot per player. Each slot latches its hit position and steps through NUM_FRAMES sprite frames on the 60 Hz frame tick.
- Arbitrates the single shared ROM read port per pixel and emits an overlay pixel that is aligned to the ROM latency.
- Sits between the game/hit logic and the VGA pixel mux.

Parameters:
- NUM_FRAMES, 8, number of blood sprite frames (ROMs) per animation.
- FRAME_HOLD, 4, frame ticks each sprite frame is displayed.
- FRAME_W, 3, width of rom_frame; equals clog2(NUM_FRAMES).

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  synchronous, active-low reset
- tick_60hz  in  1  one-cycle pulse per video frame (vblank)
- hit_p1  in  1  one-cycle pulse: player 1 struck
- hit_x_p1  in  10  splatter top-left x, sampled on hit_p1
- hit_y_p1  in  10  splatter top-left y, sampled on hit_p1
- hit_p2  in  1  one-cycle pulse: player 2 struck
- hit_x_p2  in  10  splatter top-left x, sampled on hit_p2
- hit_y_p2  in  10  splatter top-left y, sampled on hit_p2
- video_on  in  1  pixel is inside the visible area
- pixel_x  in  10  current scan x
- pixel_y  in  10  current scan y
- rom_row  out  6  ROM row address
- rom_col  out  6  ROM col address
- rom_frame  out  FRAME_W  selects which frame ROM output feeds rom_color
- rom_color  in  12  ROM data, valid 1 cycle after address
- blood_on  out  1  overlay pixel is opaque
- blood_rgb  out  12  overlay colour
- busy_p1  out  1  player 1 slot animating
- busy_p2  out  1  player 2 slot animating

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Both slots go to IDLE; pending flags cleared; frame and hold counters cleared to 0.
  - Outputs blood_on=0, blood_rgb=0, busy_p*=0.
  - rom_row, rom_col and rom_frame read 0.
  - A reset mid-animation aborts the animation immediately.
- Hit capture:
  - hit_pN sets pendingN and latches hit_x/hit_y into a pending position register.
  - A second hit before the next tick overwrites the pending position.
- Slot FSM, per slot:
  - IDLE -> ACTIVE on tick_60hz with pending=1.
  - Entering ACTIVE: position := pending position, frame := 0, hold := 0, pending := 0.
  - In ACTIVE, on each tick: if hold == FRAME_HOLD-1 then hold := 0 and frame++, else hold++.
  - On a tick with frame == NUM_FRAMES-1 and hold == FRAME_HOLD-1: go to IDLE.
  - A tick with pending=1 while ACTIVE is a retrigger: restart at frame 0 with the new position. Retrigger takes priority over end-of-animation on the same tick.
  - A hit pulse and tick in the same cycle: the hit is applied on that tick.
  - State changes only on ticks, so there is no mid-frame tearing.
- busy_pN = 1 in ACTIVE.
- Hit test, combinational, per slot:
  - dx = pixel_x - x and dy = pixel_y - y, 10-bit unsigned wrap.
  - inN = ACTIVE & video_on & dx[9:6]==0 & dy[9:6]==0.
- Arbitration:
  - Only one slot in box: that slot wins.
  - Both slots in box: the slot started most recently wins (a last_started register updates on each IDLE->ACTIVE or retrigger).
  - Both started on the same tick: player 1 wins.
- Address outputs (combinational):
  - rom_row = dy[5:0], rom_col = dx[5:0], rom_frame = winner's frame.
  - All three are 0 when no slot is in box.
- Pipeline:
  - sel_d1 := (in1 | in2) is registered every cycle.
  - Output latency is 1 cycle from pixel_x/pixel_y to blood_on/blood_rgb.
  - blood_on = sel_d1 & (rom_color != 12'h000); black is transparent.
  - blood_rgb = blood_on ? rom_color : 0.
- Edges:
  - Sprite clipping at the screen edge is implicit: no video_on, no overlay.
  - Positions within 63 of 1023 wrap through the unsigned subtract. That is acceptable because the game clamps hit positions to 0..639 x 0..479.

Decomposition:
- Package blood_fx_pkg holds:
  - SPRITE_DIM=64, COLOR_W=12, TRANSPARENT=12'h000
  - slot state enum {IDLE, ACTIVE}
- Sub-module blood_fx_slot, instantiated twice, contains:
  - pending capture, position register, FSM, frame/hold counters
  - dx/dy hit test; outputs in_box, row, col, frame, started pulse
- The top level holds last_started, the arbiter mux and the latency register.

Test Plan:
- Reset: hold reset_n=0 during hits and ticks -> busy_p1=busy_p2=0, blood_on=0, rom_row=rom_col=0.
- Basic splatter:
  - Stimulus: hit_p1 at (100,200), then tick. Drive pixel (100,200) and return rom_color=12'hE00 next cycle.
  - Required: busy_p1=1; rom_row=0, rom_col=0, rom_frame=0; blood_on=1, blood_rgb=12'hE00.
  - Pixel (164,200) -> blood_on=0.
- Progression:
  - 4 ticks after start -> rom_frame=1.
  - 32nd tick -> busy_p1=0.
- Overlap:
  - P1 at (100,100), P2 at (120,100) one tick later; pixel (130,110) -> rom_row=10, rom_col=10, P2's frame selected.
  - Both started on the same tick -> P1's frame is selected.
- Retrigger: hit_p1 at (300,50) while P1 is at frame 5; next tick -> rom_frame=0, hit box now at (300,50).
- Transparency and blanking:
  - rom_color=0 in box -> blood_on=0.
  - video_on=0 in box -> blood_on=0.
  - reset_n pulse at frame 3 -> busy_p1=0 next cycle.

Source files
------------

// File: rtl/blood_fx_pkg.sv
// Shared constants and types for the blood-splatter overlay sequencer.
package blood_fx_pkg;

  localparam int unsigned SPRITE_DIM = 64;
  localparam int unsigned ADDR_W     = $clog2(SPRITE_DIM);
  localparam int unsigned COLOR_W    = 12;
  localparam int unsigned COORD_W    = 10;

  localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

endpackage

// File: rtl/blood_fx_if.sv
// Shared sprite ROM read port: address out from the controller, colour back from the ROM.
interface blood_fx_if
  import blood_fx_pkg::*;
#(
  parameter int unsigned FRAME_W = 3
) ();

  logic [ADDR_W-1:0]  rom_row;
  logic [ADDR_W-1:0]  rom_col;
  logic [FRAME_W-1:0] rom_frame;
  logic [COLOR_W-1:0] rom_color;

  modport master (output rom_row, output rom_col, output rom_frame, input rom_color);
  modport slave  (input rom_row, input rom_col, input rom_frame, output rom_color);

endinterface

// File: rtl/blood_fx_slot.sv
// One per-player effect slot: hit capture, frame sequencing on the 60 Hz tick, and box hit test.
module blood_fx_slot
  import blood_fx_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned FRAME_HOLD = 4,
  parameter int unsigned FRAME_W    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick_60hz,
  input  logic               hit,
  input  pos_t               hit_pos,
  input  logic               video_on,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               busy,
  output logic               in_box_c,
  output logic [ADDR_W-1:0]  row_c,
  output logic [ADDR_W-1:0]  col_c,
  output logic [FRAME_W-1:0] frame,
  output logic               started_c
);

  localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);

  slot_state_e        state_q, state_d;
  logic               pending_q, pending_d;
  pos_t               pend_pos_q, pend_pos_d;
  pos_t               pos_q, pos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [COORD_W-1:0] dx, dy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      pend_pos_q <= '0;
      pos_q      <= '0;
      frame_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_pos_q <= pend_pos_d;
      pos_q      <= pos_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
    end
  end

  // A hit coinciding with the tick is taken directly, bypassing the pending register.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pend_pos_d = pend_pos_q;
    pos_d      = pos_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    started_c  = 1'b0;

    if (hit) begin
      pending_d  = 1'b1;
      pend_pos_d = hit_pos;
    end

    if (tick_60hz) begin
      pending_d = 1'b0;
      if (pending_q || hit) begin
        started_c = 1'b1;
        state_d   = ACTIVE;
        pos_d     = hit ? hit_pos : pend_pos_q;
        frame_d   = '0;
        hold_d    = '0;
      end else if (state_q == ACTIVE) begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (frame_q == FRAME_LAST) begin
            state_d = IDLE;
            frame_d = '0;
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end
  end

  // Unsigned wrap makes pixels left of / above the box fall outside it.
  assign dx        = pixel_x - pos_q.x;
  assign dy        = pixel_y - pos_q.y;
  assign busy      = (state_q == ACTIVE);
  assign in_box_c  = busy && video_on
                     && (dx[COORD_W-1:ADDR_W] == '0) && (dy[COORD_W-1:ADDR_W] == '0);
  assign row_c     = dy[ADDR_W-1:0];
  assign col_c     = dx[ADDR_W-1:0];
  assign frame     = frame_q;

endmodule

// File: rtl/blood_fx_controller.sv
// Two-player blood-splatter overlay: arbitrates the shared sprite ROM port and aligns the
// overlay pixel to the ROM's one-cycle read latency.
module blood_fx_controller
  import blood_fx_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned FRAME_HOLD = 4,
  parameter int unsigned FRAME_W    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick_60hz,
  input  logic               hit_p1,
  input  logic [COORD_W-1:0] hit_x_p1,
  input  logic [COORD_W-1:0] hit_y_p1,
  input  logic               hit_p2,
  input  logic [COORD_W-1:0] hit_x_p2,
  input  logic [COORD_W-1:0] hit_y_p2,
  input  logic               video_on,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  blood_fx_if.master         rom,
  output logic               blood_on,
  output logic [COLOR_W-1:0] blood_rgb,
  output logic               busy_p1,
  output logic               busy_p2
);

  pos_t               hit_pos_p1, hit_pos_p2;
  logic               in1, in2, st1, st2, sel_p2;
  logic [ADDR_W-1:0]  row1, row2, col1, col2;
  logic [FRAME_W-1:0] frame1, frame2;
  logic               last_p2_q;
  logic               sel_d1;

  assign hit_pos_p1 = '{x: hit_x_p1, y: hit_y_p1};
  assign hit_pos_p2 = '{x: hit_x_p2, y: hit_y_p2};

  blood_fx_slot #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FRAME_W    (FRAME_W)
  ) u_slot_p1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_60hz (tick_60hz),
    .hit       (hit_p1),
    .hit_pos   (hit_pos_p1),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .busy      (busy_p1),
    .in_box_c  (in1),
    .row_c     (row1),
    .col_c     (col1),
    .frame     (frame1),
    .started_c (st1)
  );

  blood_fx_slot #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FRAME_W    (FRAME_W)
  ) u_slot_p2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_60hz (tick_60hz),
    .hit       (hit_p2),
    .hit_pos   (hit_pos_p2),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .busy      (busy_p2),
    .in_box_c  (in2),
    .row_c     (row2),
    .col_c     (col2),
    .frame     (frame2),
    .started_c (st2)
  );

  // Player 1 takes simultaneous starts, so it only yields when player 2 started alone later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_p2_q <= 1'b0;
      sel_d1    <= 1'b0;
    end else begin
      sel_d1 <= in1 | in2;
      if (st1) begin
        last_p2_q <= 1'b0;
      end else if (st2) begin
        last_p2_q <= 1'b1;
      end
    end
  end

  assign sel_p2 = in2 && (!in1 || last_p2_q);

  always_comb begin
    rom.rom_row   = '0;
    rom.rom_col   = '0;
    rom.rom_frame = '0;
    if (sel_p2) begin
      rom.rom_row   = row2;
      rom.rom_col   = col2;
      rom.rom_frame = frame2;
    end else if (in1) begin
      rom.rom_row   = row1;
      rom.rom_col   = col1;
      rom.rom_frame = frame1;
    end
  end

  assign blood_on  = sel_d1 && (rom.rom_color != TRANSPARENT);
  assign blood_rgb = blood_on ? rom.rom_color : '0;

endmodule

// File: tb/tb_blood_fx_controller.sv
// Directed bench for blood_fx_controller: reset, splatter, progression, overlap, retrigger, blanking.
module tb_blood_fx_controller;
  import blood_fx_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick_60hz;
  logic        hit_p1, hit_p2;
  logic [9:0]  hit_x_p1, hit_y_p1, hit_x_p2, hit_y_p2;
  logic        video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic        blood_on;
  logic [11:0] blood_rgb;
  logic        busy_p1, busy_p2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blood_fx_if #(.FRAME_W(3)) rom_bus ();

  blood_fx_controller #(
    .NUM_FRAMES (8),
    .FRAME_HOLD (4),
    .FRAME_W    (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_60hz (tick_60hz),
    .hit_p1    (hit_p1),
    .hit_x_p1  (hit_x_p1),
    .hit_y_p1  (hit_y_p1),
    .hit_p2    (hit_p2),
    .hit_x_p2  (hit_x_p2),
    .hit_y_p2  (hit_y_p2),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .rom       (rom_bus),
    .blood_on  (blood_on),
    .blood_rgb (blood_rgb),
    .busy_p1   (busy_p1),
    .busy_p2   (busy_p2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_60hz = 1'b1;
      @(negedge clk) tick_60hz = 1'b0;
    end
  endtask

  task automatic hit1(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    hit_p1 = 1'b1; hit_x_p1 = x; hit_y_p1 = y;
    @(negedge clk) hit_p1 = 1'b0;
  endtask

  task automatic hit2(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    hit_p2 = 1'b1; hit_x_p2 = x; hit_y_p2 = y;
    @(negedge clk) hit_p2 = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    pixel_x = x; pixel_y = y;
    #1;
  endtask

  // Next cycle: the ROM answers the address presented during the previous cycle.
  task automatic rom_reply(input logic [11:0] c);
    @(negedge clk);
    rom_bus.rom_color = c;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; tick_60hz = 1'b0;
    hit_p1 = 1'b0; hit_p2 = 1'b0;
    hit_x_p1 = '0; hit_y_p1 = '0; hit_x_p2 = '0; hit_y_p2 = '0;
    video_on = 1'b1; pixel_x = '0; pixel_y = '0;
    rom_bus.rom_color = 12'hE00;

    // Hits and ticks while reset is held must be ignored.
    @(negedge clk);
    hit_p1 = 1'b1; hit_x_p1 = 10'd100; hit_y_p1 = 10'd200;
    hit_p2 = 1'b1; hit_x_p2 = 10'd100; hit_y_p2 = 10'd200;
    tick_60hz = 1'b1;
    @(negedge clk);
    hit_p1 = 1'b0; hit_p2 = 1'b0; tick_60hz = 1'b0;
    repeat (2) @(negedge clk);
    pix(10'd100, 10'd200);
    chk("rst_busy_p1", 32'(busy_p1), 32'd0);
    chk("rst_busy_p2", 32'(busy_p2), 32'd0);
    chk("rst_blood_on", 32'(blood_on), 32'd0);
    chk("rst_rom_row", 32'(rom_bus.rom_row), 32'd0);
    chk("rst_rom_col", 32'(rom_bus.rom_col), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Basic splatter at (100,200)
    hit1(10'd100, 10'd200);
    tick_n(1);
    pix(10'd100, 10'd200);
    chk("basic_busy_p1", 32'(busy_p1), 32'd1);
    chk("basic_rom_row", 32'(rom_bus.rom_row), 32'd0);
    chk("basic_rom_col", 32'(rom_bus.rom_col), 32'd0);
    chk("basic_rom_frame", 32'(rom_bus.rom_frame), 32'd0);
    rom_reply(12'hE00);
    chk("basic_blood_on", 32'(blood_on), 32'd1);
    chk("basic_blood_rgb", 32'(blood_rgb), 32'hE00);
    pix(10'd164, 10'd200);
    rom_reply(12'hE00);
    chk("edge_x64_blood_on", 32'(blood_on), 32'd0);

    // Black is transparent; blanking suppresses the overlay.
    pix(10'd100, 10'd200);
    rom_reply(12'h000);
    chk("transp_blood_on", 32'(blood_on), 32'd0);
    chk("transp_blood_rgb", 32'(blood_rgb), 32'd0);
    video_on = 1'b0;
    pix(10'd100, 10'd200);
    rom_reply(12'hE00);
    chk("blank_blood_on", 32'(blood_on), 32'd0);
    video_on = 1'b1;

    // Progression: frame 1 after 4 ticks, idle on the 32nd tick.
    tick_n(3);
    pix(10'd100, 10'd200);
    chk("prog_t3_frame", 32'(rom_bus.rom_frame), 32'd0);
    tick_n(1);
    pix(10'd100, 10'd200);
    chk("prog_t4_frame", 32'(rom_bus.rom_frame), 32'd1);
    tick_n(27);
    pix(10'd100, 10'd200);
    chk("prog_t31_frame", 32'(rom_bus.rom_frame), 32'd7);
    chk("prog_t31_busy", 32'(busy_p1), 32'd1);
    tick_n(1);
    pix(10'd100, 10'd200);
    chk("prog_t32_busy", 32'(busy_p1), 32'd0);

    // Overlap: P2 started later wins the shared pixel.
    hit1(10'd100, 10'd100);
    tick_n(1);
    hit2(10'd120, 10'd100);
    tick_n(4);
    pix(10'd130, 10'd110);
    chk("ovl_rom_row", 32'(rom_bus.rom_row), 32'd10);
    chk("ovl_rom_col", 32'(rom_bus.rom_col), 32'd10);
    chk("ovl_rom_frame", 32'(rom_bus.rom_frame), 32'd0);
    pix(10'd105, 10'd105);
    chk("ovl_p1only_col", 32'(rom_bus.rom_col), 32'd5);
    chk("ovl_p1only_frame", 32'(rom_bus.rom_frame), 32'd1);

    // Same-tick start on both slots: P1 wins.
    @(negedge clk);
    hit_p1 = 1'b1; hit_x_p1 = 10'd100; hit_y_p1 = 10'd100;
    hit_p2 = 1'b1; hit_x_p2 = 10'd120; hit_y_p2 = 10'd100;
    @(negedge clk);
    hit_p1 = 1'b0; hit_p2 = 1'b0;
    tick_n(1);
    pix(10'd130, 10'd110);
    chk("same_rom_col", 32'(rom_bus.rom_col), 32'd30);
    chk("same_rom_row", 32'(rom_bus.rom_row), 32'd10);
    chk("same_busy_p2", 32'(busy_p2), 32'd1);

    // Retrigger at frame 5 restarts at the new position.
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    hit1(10'd100, 10'd200);
    tick_n(21);
    pix(10'd100, 10'd200);
    chk("retrig_pre_frame", 32'(rom_bus.rom_frame), 32'd5);
    hit1(10'd300, 10'd50);
    tick_n(1);
    pix(10'd310, 10'd60);
    chk("retrig_frame", 32'(rom_bus.rom_frame), 32'd0);
    chk("retrig_rom_col", 32'(rom_bus.rom_col), 32'd10);
    chk("retrig_rom_row", 32'(rom_bus.rom_row), 32'd10);
    pix(10'd100, 10'd200);
    rom_reply(12'hE00);
    chk("retrig_old_box_off", 32'(blood_on), 32'd0);

    // Reset mid-animation at frame 3 aborts.
    tick_n(12);
    pix(10'd310, 10'd60);
    chk("abort_pre_frame", 32'(rom_bus.rom_frame), 32'd3);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("abort_busy_p1", 32'(busy_p1), 32'd0);

    // Hit and tick in the same cycle start immediately.
    @(negedge clk);
    hit_p2 = 1'b1; hit_x_p2 = 10'd50; hit_y_p2 = 10'd60; tick_60hz = 1'b1;
    @(negedge clk);
    hit_p2 = 1'b0; tick_60hz = 1'b0;
    pix(10'd51, 10'd62);
    chk("hittick_busy_p2", 32'(busy_p2), 32'd1);
    chk("hittick_rom_col", 32'(rom_bus.rom_col), 32'd1);
    chk("hittick_rom_row", 32'(rom_bus.rom_row), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
